dmem_store_buffer: RTL and testbench

Word-wide posted-write buffer inserted between the `riscv_pipeline` data port and `data_mem`. CPU stores are accepted into a small FIFO and retire to memory in cycles when the CPU is not loading. Loads forward the youngest matching buffered store, so the CPU never sees stale data. `stall` backpressures the pipeline only when the buffer cannot accept a store.

---
 rtl/dmem_store_buffer.sv | 101 ++++++++++
 tb/tb_dmem_store_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the CPU data port and data_mem; loads forward the youngest buffered store.
// Stores retire on cycles without a load; stall asserts only when full and no drain frees a slot.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        sb_empty,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]   adr_q  [DEPTH];
  logic [31:0]   adr_d  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] fwd_idx;
  logic          drain;
  logic          push;

  // Outputs are gated by rst so the port goes quiet the instant reset rises.
  always_comb begin
    drain     = ~rst & ~cpu_rd & (count_q != '0);
    stall     = ~rst & cpu_wr & (count_q == FULL_CNT) & ~drain;
    push      = ~rst & cpu_wr & ~stall;
    mem_rd    = ~rst & cpu_rd;
    mem_wr    = drain;
    mem_adr   = '0;
    mem_wdata = '0;
    if (mem_rd) begin
      mem_adr = cpu_adr;
    end else if (drain) begin
      mem_adr   = adr_q[head_q];
      mem_wdata = data_q[head_q];
    end
  end

  assign sb_empty = (count_q == '0);

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    cpu_rdata = mem_rdata;
    fwd_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (cpu_rd && ((PW+1)'(i) < count_q) && (adr_q[fwd_idx] == cpu_adr)) begin
        cpu_rdata = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    adr_d  = adr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      adr_d[tail_q]  = cpu_adr;
      data_d[tail_q] = cpu_wdata;
      tail_d         = tail_q + 1'b1;
    end
    if (drain) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(drain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      adr_q   <= adr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, reset/wrap sequences, and random traffic vs a queue model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_rd, cpu_wr;
  logic        stall, sb_empty;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .stall(stall), .sb_empty(sb_empty),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  // Word memory standing in for data_mem.
  logic [31:0] tbmem [0:255];
  assign mem_rdata = tbmem[mem_adr[9:2]];
  always @(posedge clk) if (mem_wr) tbmem[mem_adr[9:2]] <= mem_wdata;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending stores plus the memory image they retire into.
  typedef struct { logic [31:0] adr; logic [31:0] data; } ent_t;
  ent_t        sbq [$];
  logic [31:0] refmem [0:255];

  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output bit acc);
    bit          drn, st;
    logic [31:0] er;
    cpu_rd = rd; cpu_wr = wr; cpu_adr = a; cpu_wdata = d;
    drn = !rd && (sbq.size() > 0);
    st  = wr && (sbq.size() == DEPTH) && !drn;
    er  = refmem[a[9:2]];
    foreach (sbq[k]) if (sbq[k].adr == a) er = sbq[k].data;
    @(negedge clk);
    chkb("stall", stall, st);
    chkb("sb_empty", sb_empty, sbq.size() == 0);
    chkb("mem_rd", mem_rd, rd);
    chkb("mem_wr", mem_wr, drn);
    if (rd) begin
      chk("mem_adr_load", mem_adr, a);
      chk("cpu_rdata", cpu_rdata, er);
    end else if (drn) begin
      chk("mem_adr_drain", mem_adr, sbq[0].adr);
      chk("mem_wdata_drain", mem_wdata, sbq[0].data);
    end else begin
      chk("mem_adr_idle", mem_adr, 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
    end
    @(posedge clk);
    if (drn) begin
      refmem[sbq[0].adr[9:2]] = sbq[0].data;
      void'(sbq.pop_front());
    end
    acc = wr && !st;
    if (acc) sbq.push_back('{a, d});
    #1;
  endtask

  task automatic drain_all();
    bit acc;
    int n = 0;
    while (sbq.size() > 0 && n < 20) begin
      step(0, 0, 32'h0, 32'h0, acc);
      n++;
    end
    chkb("drain_bounded", sbq.size() == 0, 1'b1);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] adr, wdata;
    logic        stall, mrd, mwr;
    logic [31:0] madr, mwdata, rdata;
    logic        empty;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] adr, logic [31:0] wd,
                              logic st, logic mrd, logic mwr, logic [31:0] madr,
                              logic [31:0] mwd, logic [31:0] rdat, logic emp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.adr = adr; v.wdata = wd;
    v.stall = st; v.mrd = mrd; v.mwr = mwr; v.madr = madr;
    v.mwdata = mwd; v.rdata = rdat; v.empty = emp;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    bit acc;
    int tries;
    bit pend;
    bit r, w;
    logic [31:0] a, d;

    //              rd wr adr        wdata          stall mrd mwr madr      mwdata        rdata         empty
    tbl[0]  = mk(0, 0, 32'h00, 32'h0,          0, 0, 0, 32'h00, 32'h0,          32'h0,          1);
    tbl[1]  = mk(0, 1, 32'h10, 32'hDEADBEEF,   0, 0, 0, 32'h00, 32'h0,          32'h0,          1);
    tbl[2]  = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h10, 32'hDEADBEEF,   32'h0,          0);
    tbl[3]  = mk(1, 0, 32'h10, 32'h0,          0, 1, 0, 32'h10, 32'h0,          32'hDEADBEEF,   1);
    tbl[4]  = mk(1, 1, 32'h20, 32'h1,          0, 1, 0, 32'h20, 32'h0,          32'h0,          1);
    tbl[5]  = mk(1, 1, 32'h20, 32'h2,          0, 1, 0, 32'h20, 32'h0,          32'h1,          0);
    tbl[6]  = mk(1, 0, 32'h20, 32'h0,          0, 1, 0, 32'h20, 32'h0,          32'h2,          0);
    tbl[7]  = mk(1, 1, 32'h44, 32'h3,          0, 1, 0, 32'h44, 32'h0,          32'h0,          0);
    tbl[8]  = mk(1, 1, 32'h48, 32'h4,          0, 1, 0, 32'h48, 32'h0,          32'h0,          0);
    tbl[9]  = mk(1, 1, 32'h4C, 32'h5,          1, 1, 0, 32'h4C, 32'h0,          32'h0,          0);
    tbl[10] = mk(0, 1, 32'h4C, 32'h5,          0, 0, 1, 32'h20, 32'h1,          32'h0,          0);
    tbl[11] = mk(1, 0, 32'h20, 32'h0,          0, 1, 0, 32'h20, 32'h0,          32'h2,          0);
    tbl[12] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h20, 32'h2,          32'h0,          0);
    tbl[13] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h44, 32'h3,          32'h0,          0);
    tbl[14] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h48, 32'h4,          32'h0,          0);
    tbl[15] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h4C, 32'h5,          32'h0,          0);
    tbl[16] = mk(0, 0, 32'h00, 32'h0,          0, 0, 0, 32'h00, 32'h0,          32'h0,          1);
    tbl[17] = mk(1, 0, 32'h20, 32'h0,          0, 1, 0, 32'h20, 32'h0,          32'h2,          1);
    tbl[18] = mk(0, 1, 32'h30, 32'h7,          0, 0, 0, 32'h00, 32'h0,          32'h0,          1);
    tbl[19] = mk(1, 1, 32'h30, 32'h9,          0, 1, 0, 32'h30, 32'h0,          32'h7,          0);
    tbl[20] = mk(1, 0, 32'h30, 32'h0,          0, 1, 0, 32'h30, 32'h0,          32'h9,          0);
    tbl[21] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h30, 32'h7,          32'h0,          0);
    tbl[22] = mk(0, 0, 32'h00, 32'h0,          0, 0, 1, 32'h30, 32'h9,          32'h0,          0);
    tbl[23] = mk(1, 0, 32'h30, 32'h0,          0, 1, 0, 32'h30, 32'h0,          32'h9,          1);

    for (int i = 0; i < 256; i++) begin
      tbmem[i]  = 32'h0;
      refmem[i] = 32'h0;
    end

    // Reset with a load pending: port must read as idle.
    rst = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_adr = 32'h44; cpu_wdata = 32'h5;
    #1;
    chkb("rst_mem_rd", mem_rd, 1'b0);
    chkb("rst_mem_wr", mem_wr, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_empty", sb_empty, 1'b1);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = 32'h0; cpu_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      cpu_rd = tbl[i].rd; cpu_wr = tbl[i].wr; cpu_adr = tbl[i].adr; cpu_wdata = tbl[i].wdata;
      @(negedge clk);
      chkb($sformatf("tbl%0d_stall", i), stall, tbl[i].stall);
      chkb($sformatf("tbl%0d_mem_rd", i), mem_rd, tbl[i].mrd);
      chkb($sformatf("tbl%0d_mem_wr", i), mem_wr, tbl[i].mwr);
      chk($sformatf("tbl%0d_mem_adr", i), mem_adr, tbl[i].madr);
      chkb($sformatf("tbl%0d_sb_empty", i), sb_empty, tbl[i].empty);
      if (tbl[i].rd) chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].rdata);
      else           chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].mwdata);
      @(posedge clk);
      #1;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    // Buffer is empty here; start the model from a clean memory image.
    for (int i = 0; i < 256; i++) begin
      tbmem[i]  = 32'h0;
      refmem[i] = 32'h0;
    end
    sbq.delete();

    // Ten stores with interleaved loads: tail wraps twice, stalls occur while loads block draining.
    for (int i = 0; i < 10; i++) begin
      a = 32'h200 + 32'(4 * i);
      d = $urandom;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 8) begin
        step(bit'($urandom_range(0, 1)), 1'b1, a, d, acc);
        tries++;
      end
      chkb("wrap_store_accepted", acc, 1'b1);
      step(1'b1, 1'b0, 32'h200 + 32'(4 * $urandom_range(0, i)), 32'h0, acc);
    end
    drain_all();
    for (int i = 0; i < 10; i++)
      chk($sformatf("wrap_mem%0d", i), tbmem[128 + i], refmem[128 + i]);

    // Reset mid-cycle with three stores buffered and a drain in progress.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), acc);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = 32'h0;
    #2;
    chkb("pre_rst_mem_wr", mem_wr, 1'b1);
    rst = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_adr = 32'h304;
    #1;
    chkb("midrst_mem_wr", mem_wr, 1'b0);
    chkb("midrst_mem_rd", mem_rd, 1'b0);
    chkb("midrst_empty", sb_empty, 1'b1);
    chkb("midrst_stall", stall, 1'b0);
    chk("midrst_mem_adr", mem_adr, 32'h0);
    sbq.delete();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, acc);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_no_write%0d", i), tbmem[192 + i], 32'h0);

    // Random traffic over a small address set so forwarding hits are frequent.
    pend = 1'b0;
    a = 32'h100; d = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        w = ($urandom_range(0, 1) == 1);
        a = 32'h100 + 32'(4 * $urandom_range(0, 7));
        d = $urandom;
      end else begin
        w = 1'b1;
      end
      r = ($urandom_range(0, 2) != 0);
      if (!w && r) a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      step(r, w, a, d, acc);
      pend = w && !acc;
    end
    drain_all();
    for (int i = 64; i < 72; i++) chk($sformatf("rand_mem%0d", i), tbmem[i], refmem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
